// File: rtl/gait_pkg.sv
// Shared types and body-geometry tables for the tripod gait sequencer.
package gait_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH0  = 3'd1,
        ST_PH1  = 3'd2,
        ST_PH2  = 3'd3,
        ST_PH3  = 3'd4
    } gait_state_e;

    localparam int NUM_LEGS   = 6;
    localparam int NUM_JOINTS = 3;
    localparam int PW_W       = 16;
    localparam int LEG_W      = NUM_JOINTS * PW_W;
    localparam int BUS_W      = NUM_LEGS * LEG_W;

    localparam int JOINT_YAW  = 1;
    localparam int JOINT_LIFT = 2;
    localparam int JOINT_KNEE = 3;

    // Bit n-1 describes leg n: group B holds legs 2/4/6, the negative side holds legs 4-6.
    localparam logic [NUM_LEGS-1:0] GROUP_B  = 6'b101010;
    localparam logic [NUM_LEGS-1:0] SIDE_NEG = 6'b111000;

    function automatic int pul_offset(input int leg, input int joint);
        return (leg - 1) * LEG_W + (joint - 1) * PW_W;
    endfunction

endpackage

// File: rtl/gait_tick_gen.sv
// Gait tick prescaler: free-running modulo-TICK_DIV counter with a synchronous clear.
module gait_tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic CLK,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = (cnt_q == LAST);

    always_ff @(posedge CLK) begin
        if (rst || clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/gait_sequencer.sv
// Tripod-gait scheduler: walks four phases of STEPS ticks each and drives
// the 18 servo pulse widths for the two alternating leg groups.
module gait_sequencer
    import gait_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int STEPS     = 25,
    parameter int CENTER    = 1500,
    parameter int YAW_STEP  = 8,
    parameter int LIFT_STEP = 4,
    parameter int PW_MIN    = 1000,
    parameter int PW_MAX    = 2000
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    output logic             busy,
    output logic [1:0]       phase,
    output logic             cycle_done,
    output logic [BUS_W-1:0] pul_bus
);

    localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [KW-1:0]     K_LAST   = KW'(STEPS - 1);
    localparam logic [PW_W-1:0]   CENTER_W = PW_W'(CENTER);
    localparam logic signed [17:0] Y_S     = 18'(YAW_STEP);
    localparam logic signed [17:0] L_S     = 18'(LIFT_STEP);
    localparam logic signed [17:0] S_S     = 18'(STEPS);
    localparam logic signed [17:0] C_S     = 18'(CENTER);
    localparam logic signed [17:0] MIN_S   = 18'(PW_MIN);
    localparam logic signed [17:0] MAX_S   = 18'(PW_MAX);

    gait_state_e       state_q;
    logic [KW-1:0]     k_q;
    logic              stop_q;
    logic              dir_q;
    logic              cycle_done_q;
    logic [BUS_W-1:0]  pul_q;
    logic [BUS_W-1:0]  pul_d;
    logic              tick;
    logic              accept;
    logic signed [17:0] m_s, ya, ha, hb, yg, hg;

    assign accept = (state_q == ST_IDLE) && start && !stop;

    gait_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK    (CLK),
        .rst    (rst),
        .clr_i  (accept),
        .tick_o (tick)
    );

    function automatic logic [PW_W-1:0] clamp_pw(input logic signed [17:0] v);
        if (v < MIN_S) return MIN_S[PW_W-1:0];
        if (v > MAX_S) return MAX_S[PW_W-1:0];
        return v[PW_W-1:0];
    endfunction

    // Offsets describe the step being entered (m = k+1), so the last step of a phase lands exactly on its endpoint.
    always_comb begin
        m_s   = $signed(18'(k_q)) + 18'sd1;
        ya    = '0;
        ha    = '0;
        hb    = '0;
        yg    = '0;
        hg    = '0;
        pul_d = '0;
        case (state_q)
            ST_PH0: begin
                ya = -(Y_S * m_s);
                hb = L_S * m_s;
            end
            ST_PH1: begin
                ya = Y_S * m_s - Y_S * S_S;
                hb = L_S * (S_S - m_s);
            end
            ST_PH2: begin
                ya = Y_S * m_s;
                ha = L_S * m_s;
            end
            ST_PH3: begin
                ya = Y_S * (S_S - m_s);
                ha = L_S * (S_S - m_s);
            end
            default: ;
        endcase
        if (dir_q) ya = -ya;
        for (int n = 1; n <= NUM_LEGS; n++) begin
            yg = GROUP_B[n-1] ? -ya : ya;
            hg = GROUP_B[n-1] ? hb : ha;
            if (SIDE_NEG[n-1]) begin
                yg = -yg;
                hg = -hg;
            end
            pul_d[pul_offset(n, JOINT_YAW)  +: PW_W] = clamp_pw(C_S + yg);
            pul_d[pul_offset(n, JOINT_LIFT) +: PW_W] = clamp_pw(C_S + hg);
            pul_d[pul_offset(n, JOINT_KNEE) +: PW_W] = clamp_pw(C_S - hg);
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            stop_q       <= 1'b0;
            dir_q        <= 1'b0;
            cycle_done_q <= 1'b0;
            pul_q        <= {(NUM_LEGS * NUM_JOINTS){CENTER_W}};
        end else begin
            cycle_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dir_q   <= dir;
                        stop_q  <= 1'b0;
                        k_q     <= '0;
                        state_q <= ST_PH0;
                    end
                end
                default: begin
                    if (stop) stop_q <= 1'b1;
                    if (tick) begin
                        pul_q <= pul_d;
                        if (k_q != K_LAST) begin
                            k_q <= k_q + KW'(1);
                        end else begin
                            k_q <= '0;
                            case (state_q)
                                ST_PH0:  state_q <= ST_PH1;
                                ST_PH1:  state_q <= ST_PH2;
                                ST_PH2:  state_q <= ST_PH3;
                                default: begin
                                    cycle_done_q <= 1'b1;
                                    if (stop_q) begin
                                        state_q <= ST_IDLE;
                                    end else begin
                                        state_q <= ST_PH0;
                                        dir_q   <= dir;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        phase = 2'd0;
        case (state_q)
            ST_PH1:  phase = 2'd1;
            ST_PH2:  phase = 2'd2;
            ST_PH3:  phase = 2'd3;
            default: phase = 2'd0;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign cycle_done = cycle_done_q;
    assign pul_bus    = pul_q;

endmodule

// File: tb/tb_gait_sequencer.sv
// Bench for gait_sequencer: cycle-level reference model with scoreboard queue,
// plus directed width tables and multi-cycle stop/dir/reset sequences.
module tb_gait_sequencer;

    localparam int TD     = 4;
    localparam int S      = 4;
    localparam int L      = 4;
    localparam int Y_MAIN = 8;
    localparam int Y_SAT  = 300;

    logic         CLK = 1'b0;
    logic         rst = 1'b1, start = 1'b0, stop = 1'b0, dir = 1'b0;
    logic         busy, busy_s, cd, cd_s;
    logic [1:0]   phase, phase_s;
    logic [287:0] bus, bus_s;

    always #5 CLK = ~CLK;

    gait_sequencer #(.TICK_DIV(TD), .STEPS(S), .CENTER(1500), .YAW_STEP(Y_MAIN),
                     .LIFT_STEP(L), .PW_MIN(1000), .PW_MAX(2000)) dut (
        .CLK(CLK), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .busy(busy), .phase(phase), .cycle_done(cd), .pul_bus(bus));

    gait_sequencer #(.TICK_DIV(TD), .STEPS(S), .CENTER(1500), .YAW_STEP(Y_SAT),
                     .LIFT_STEP(L), .PW_MIN(1000), .PW_MAX(2000)) dut_sat (
        .CLK(CLK), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .busy(busy_s), .phase(phase_s), .cycle_done(cd_s), .pul_bus(bus_s));

    typedef struct {
        logic [287:0] bus;
        logic [287:0] bus_s;
        logic         busy;
        logic [1:0]   phase;
        logic         cd;
    } exp_t;

    typedef struct {
        int leg;
        int joint;
        int exp;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0;
    int   m_state = 0, m_k = 0, m_pre = 0;
    bit   m_stop = 0, m_dir = 0, m_cd = 0;
    int   m_w[6][3], m_ws[6][3];
    int   sat_min = 1500, sat_max = 1500;
    int   cd_count = 0;

    function automatic int calc_w(int ph, int m, bit d, int leg, int joint, int yst);
        int ya = 0, ha = 0, hb = 0, yg, hg, s, v;
        case (ph)
            0: begin ya = -yst * m;           hb = L * m;       end
            1: begin ya = -yst * S + yst * m; hb = L * (S - m); end
            2: begin ya = yst * m;            ha = L * m;       end
            default: begin ya = yst * S - yst * m; ha = L * (S - m); end
        endcase
        if (leg % 2 == 1) begin yg = ya;  hg = ha; end
        else              begin yg = -ya; hg = hb; end
        if (d) yg = -yg;
        s = (leg <= 3) ? 1 : -1;
        case (joint)
            1: v = 1500 + s * yg;
            2: v = 1500 + s * hg;
            default: v = 1500 - s * hg;
        endcase
        if (v < 1000) v = 1000;
        if (v > 2000) v = 2000;
        return v;
    endfunction

    function automatic logic [287:0] pack(input int w[6][3]);
        logic [287:0] r = '0;
        for (int l = 0; l < 6; l++)
            for (int j = 0; j < 3; j++)
                r[l*48 + j*16 +: 16] = 16'(w[l][j]);
        return r;
    endfunction

    function automatic int get_w(int leg, int joint);
        return int'(bus[(leg-1)*48 + (joint-1)*16 +: 16]);
    endfunction

    // Reference model: advances one clock edge using the inputs the DUT samples at that edge.
    task automatic model_edge();
        bit tick_now, acc;
        if (rst) begin
            m_state = 0; m_k = 0; m_stop = 0; m_dir = 0; m_pre = 0; m_cd = 0;
            for (int l = 0; l < 6; l++)
                for (int j = 0; j < 3; j++) begin
                    m_w[l][j] = 1500;
                    m_ws[l][j] = 1500;
                end
            return;
        end
        tick_now = (m_pre == TD - 1);
        acc      = (m_state == 0) && start && !stop;
        m_pre    = (acc || tick_now) ? 0 : m_pre + 1;
        m_cd     = 0;
        if (m_state == 0) begin
            if (acc) begin
                m_dir = dir; m_stop = 0; m_state = 1; m_k = 0;
            end
        end else begin
            if (tick_now) begin
                for (int l = 0; l < 6; l++)
                    for (int j = 0; j < 3; j++) begin
                        m_w[l][j]  = calc_w(m_state - 1, m_k + 1, m_dir, l + 1, j + 1, Y_MAIN);
                        m_ws[l][j] = calc_w(m_state - 1, m_k + 1, m_dir, l + 1, j + 1, Y_SAT);
                    end
                if (m_k < S - 1) begin
                    m_k++;
                end else begin
                    m_k = 0;
                    if (m_state == 4) begin
                        m_cd = 1;
                        if (m_stop) m_state = 0;
                        else begin m_state = 1; m_dir = dir; end
                    end else begin
                        m_state++;
                    end
                end
            end
            if (stop) m_stop = 1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        int   v;
        @(posedge CLK);
        model_edge();
        e.bus   = pack(m_w);
        e.bus_s = pack(m_ws);
        e.busy  = (m_state != 0);
        e.phase = (m_state == 0) ? 2'd0 : 2'(m_state - 1);
        e.cd    = m_cd;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (bus !== e.bus) begin
            n_bad++;
            $display("FAIL pul_bus @%0t: got %h, expected %h", $time, bus, e.bus);
        end
        n_cmp++;
        if (bus_s !== e.bus_s) begin
            n_bad++;
            $display("FAIL pul_bus_sat @%0t: got %h, expected %h", $time, bus_s, e.bus_s);
        end
        n_cmp++;
        if ({busy, phase, cd} !== {e.busy, e.phase, e.cd} ||
            {busy_s, phase_s, cd_s} !== {e.busy, e.phase, e.cd}) begin
            n_bad++;
            $display("FAIL ctrl @%0t: got busy/phase/done %b/%0d/%b (sat %b/%0d/%b), expected %b/%0d/%b",
                     $time, busy, phase, cd, busy_s, phase_s, cd_s, e.busy, e.phase, e.cd);
        end
        if (cd === 1'b1) cd_count++;
        for (int l = 0; l < 6; l++) begin
            v = int'(bus_s[l*48 +: 16]);
            if (v < sat_min) sat_min = v;
            if (v > sat_max) sat_max = v;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_center(input string name);
        for (int l = 1; l <= 6; l++)
            for (int j = 1; j <= 3; j++)
                check(name, get_w(l, j), 1500);
    endtask

    vec_t t_first[10];
    vec_t t_ph2[3];
    bit   idle_seen;

    initial begin
        t_first = '{'{1,1,1492}, '{1,2,1500}, '{1,3,1500}, '{2,1,1508}, '{2,2,1504},
                    '{2,3,1496}, '{4,1,1492}, '{4,2,1496}, '{4,3,1504}, '{5,1,1508}};
        t_ph2   = '{'{1,2,1516}, '{1,3,1484}, '{3,1,1532}};

        rst = 1'b1;
        run(2);
        rst = 1'b0;
        step();
        check_all_center("reset_width");
        check("reset_busy", int'(busy), 0);
        check("reset_phase", int'(phase), 0);

        // Forward walk; a start while busy must be ignored.
        start = 1'b1; dir = 1'b0;
        step();
        start = 1'b0;
        run(4);
        for (int i = 0; i < 10; i++)
            check($sformatf("first_tick_leg%0d_j%0d", t_first[i].leg, t_first[i].joint),
                  get_w(t_first[i].leg, t_first[i].joint), t_first[i].exp);
        start = 1'b1;
        step();
        start = 1'b0;
        run(27);
        for (int l = 1; l <= 6; l++) check("end_ph1_yaw", get_w(l, 1), 1500);
        check("end_ph1_phase", int'(phase), 2);
        run(16);
        for (int i = 0; i < 3; i++)
            check($sformatf("ph2_m4_leg%0d_j%0d", t_ph2[i].leg, t_ph2[i].joint),
                  get_w(t_ph2[i].leg, t_ph2[i].joint), t_ph2[i].exp);
        check("ph2_end_phase", int'(phase), 3);

        // Stop in mid-PH1 of the second cycle: finish the cycle, one done pulse, then idle.
        run(40);
        cd_count = 0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        idle_seen = 0;
        for (int i = 0; i < 200 && !idle_seen; i++) begin
            step();
            if (busy === 1'b0) idle_seen = 1;
        end
        check("stop_reaches_idle", int'(idle_seen), 1);
        check("stop_done_pulses", cd_count, 1);
        check_all_center("stop_width");

        stop = 1'b1;
        step();
        stop = 1'b0;
        run(10);
        check("idle_stop_busy", int'(busy), 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        run(3);
        check("start_stop_busy", int'(busy), 0);

        // Reverse walk; dir flip mid-cycle only applies after the PH3->PH0 wrap.
        start = 1'b1; dir = 1'b1;
        step();
        start = 1'b0;
        run(4);
        check("rev_leg1_yaw", get_w(1, 1), 1508);
        check("rev_leg2_yaw", get_w(2, 1), 1492);
        run(16);
        dir = 1'b0;
        run(28);
        check("rev_hold_leg3_yaw", get_w(3, 1), 1468);
        run(20);
        check("after_wrap_leg1_yaw", get_w(1, 1), 1492);

        // Reset in mid-PH2 of the second cycle.
        run(32);
        check("pre_rst_phase", int'(phase), 2);
        rst = 1'b1;
        step();
        check_all_center("rst_mid_width");
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(cd), 0);
        rst = 1'b0;
        run(5);

        check("sat_yaw_min", sat_min, 1000);
        check("sat_yaw_max", sat_max, 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
